counter_slot_arbiter: RTL and testbench
=======================================

# counter_slot_arbiter

Time-slot arbiter and sequencer for the shared 8-bit ripple up-counter. Up to N_REQ requesters each ask for a timed interval of (limit+1) clock cycles; the block grants one requester at a time round-robin, holds the counter in reset while idle, releases it for the slot, watches its Q output against the winner's limit, and pulses done at expiry. It sits between the requesting control blocks and the counter instance, whose reset pin it drives exclusively.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- CNT_W, default 8: counter width; must match the counter's Q width.
- clk  in  1: single clock; all state updates on rising edge.
- reset  in  1: synchronous, active-high reset.
- req  in  N_REQ: level request per requester; held high until done or deliberately dropped to abort.
- limit  in  N_REQ*CNT_W: packed per-requester terminal count, requester i at bits [i*CNT_W +: CNT_W]; sampled only at grant.
- cnt_q  in  CNT_W: counter Q output.
- cnt_reset  out  1: drives the counter's reset; registered.
- grant  out  N_REQ: one-hot owner of the current slot; all-zero when idle.
- done  out  1: one-cycle pulse at slot expiry, coincident with the last grant cycle.
- busy  out  1: high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE. Registered state, outputs, latched limit (lim_q), owner index and round-robin pointer (rr).
- Reset: state=IDLE, grant=0, done=0, busy=0, cnt_reset=1, rr=0, lim_q=0.
- IDLE: cnt_reset=1. If any req bit set, select the first set bit searching upward from rr with wrap; latch its limit into lim_q, set grant one-hot, cnt_reset=0, busy=1, rr=winner+1 mod N_REQ; go RUN. No request: stay.
- RUN: compare cnt_q against lim_q every cycle.
  - req[owner]=0 (abort): go IDLE; grant=0, cnt_reset=1, busy=0, done stays 0. Abort takes priority over match.
  - cnt_q == lim_q: go DONE; done=1, cnt_reset=1, grant held.
  - else stay.
- DONE: one cycle; next edge to IDLE with done=0, grant=0, busy=0, cnt_reset stays 1.
- Requests from non-owners while busy are ignored; no preemption. limit changes after grant have no effect.
- Compare is exact equality at CNT_W bits; lim_q=0 and lim_q=2^CNT_W-1 are legal, no special cases.

## Timing
- Edge E0: grant registered, cnt_reset falls. Counter increments at E1, E2, ...; after Ek, Q=k.
- Controller samples cnt_q=L at edge E(L+1): done and cnt_reset=1 registered there. Slot length (grant high) = L+2 cycles including DONE; done high during cycle after E(L+1).
- Request-to-grant latency: 1 cycle from IDLE. Back-to-back slot period: L+3 cycles (RUN L+1, DONE 1, IDLE 1).
- cnt_reset is asserted in every cycle that is not RUN, so the counter starts each slot from 0.
- reset during RUN or DONE: next edge returns to reset values; no done pulse; counter re-held in reset.
- reset and req high together: reset wins; arbitration starts the cycle after reset deasserts.

## Test plan
- Single request: reset 2 cycles, req=4'b0001, limit0=5 -> grant=0001 one cycle after req, done pulses exactly 6 cycles after grant rises, grant falls 1 cycle after done, cnt_reset low for exactly 6 cycles.
- Round-robin: req=4'b1111 held, all limits=2 -> grants in order 0001,0010,0100,1000,0001, each slot 5 cycles apart, 4 done pulses in 20 cycles.
- Boundary limits: limit=0 -> done 1 cycle after grant; limit=255 -> done 256 cycles after grant, cnt_q seen 255 at the expiry edge, no wrap to 0 before done.
- Abort: limit=10, drop req[owner] 3 cycles after grant -> grant=0 and cnt_reset=1 next edge, done never pulses, next pending requester granted 1 cycle later.
- Reset mid-slot: reset high 4 cycles into a limit=20 slot -> next edge grant=0, done=0, busy=0, cnt_reset=1, rr=0; requester 0 granted first afterward.
- Limit change after grant: limit1 changes 7->2 during slot of requester 1 -> done still at 8 cycles after grant.

Source files
------------

// File: rtl/counter_slot_arbiter.sv
// counter_slot_arbiter
//   Round-robin time-slot arbiter for a shared ripple up-counter. One requester
//   at a time owns the counter for (limit+1) counting cycles. The counter is
//   held in reset whenever no slot is running. done pulses at expiry.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   req        in   N_REQ level requests; dropping the owner's bit aborts its slot
//   limit      in   N_REQ packed terminal counts, requester i at [i*CNT_W +: CNT_W]
//   cnt_q      in   counter Q output
//   cnt_reset  out  counter reset, registered, high in every non-RUN cycle
//   grant      out  one-hot slot owner, zero when idle
//   done       out  one-cycle expiry pulse, coincident with the last grant cycle
//   busy       out  high in RUN and DONE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | counter held in reset, arbitrating among pending requests
// RUN   | counter released, comparing cnt_q against latched limit
// DONE  | one-cycle expiry, done high, counter back in reset
module counter_slot_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] limit,
    input  logic [CNT_W-1:0]       cnt_q,
    output logic                   cnt_reset,
    output logic [N_REQ-1:0]       grant,
    output logic                   done,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   lim_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_q;

    logic [2*N_REQ-1:0] req_rot;
    logic               found;
    logic [IDX_W-1:0]   pos_idx;
    logic [IDX_W:0]     win_sum;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   rr_next;
    logic [CNT_W-1:0]   win_lim;

    // Rotating a doubled copy of req right by rr puts the search start at bit 0,
    // so the first set bit is the round-robin winner offset from rr.
    always_comb begin
        req_rot = {req, req} >> rr_q;
        found   = 1'b0;
        pos_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                pos_idx = IDX_W'(k);
            end
        end
        win_sum = {1'b0, rr_q} + {1'b0, pos_idx};
        if (win_sum >= (IDX_W+1)'(N_REQ)) begin
            win_sum = win_sum - (IDX_W+1)'(N_REQ);
        end
        win_idx = win_sum[IDX_W-1:0];
        rr_next = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + IDX_W'(1);
        win_lim = limit[int'(win_idx)*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cnt_reset <= 1'b1;
            rr_q      <= '0;
            lim_q     <= '0;
            owner_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done      <= 1'b0;
                    cnt_reset <= 1'b1;
                    if (found) begin
                        state_q   <= RUN;
                        grant     <= ONE_HOT_0 << win_idx;
                        lim_q     <= win_lim;
                        owner_q   <= win_idx;
                        rr_q      <= rr_next;
                        cnt_reset <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort wins over a same-cycle match: no done for a dropped slot.
                    if (!req[owner_q]) begin
                        state_q   <= IDLE;
                        grant     <= '0;
                        cnt_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (cnt_q == lim_q) begin
                        state_q   <= DONE;
                        done      <= 1'b1;
                        cnt_reset <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done      <= 1'b0;
                    grant     <= '0;
                    busy      <= 1'b0;
                    cnt_reset <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    grant     <= '0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cnt_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Testbench for counter_slot_arbiter with a behavioural 8-bit counter and a
// slot-level reference model (round-robin pointer, expected slot lengths).
module tb_counter_slot_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] limit = '0;
    logic [W-1:0]   cnt_q = '0;
    logic           cnt_reset;
    logic [N-1:0]   grant;
    logic           done;
    logic           busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    counter_slot_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .limit     (limit),
        .cnt_q     (cnt_q),
        .cnt_reset (cnt_reset),
        .grant     (grant),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Shared counter: synchronous reset, free-running otherwise.
    always @(posedge clk) begin
        if (cnt_reset === 1'b0) cnt_q <= cnt_q + 1'b1;
        else                    cnt_q <= '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_limit(input int i, input int v);
        logic [W-1:0] lv;
        lv = v[W-1:0];
        limit[i*W +: W] = lv;
    endtask

    function automatic int get_limit(input int i);
        logic [W-1:0] lv;
        lv = limit[i*W +: W];
        return int'(lv);
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        req = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Ticks until grant is non-zero or the budget runs out.
    task automatic wait_grant(input int max, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            tick();
            n++;
            if (grant != '0) ok = 1'b1;
        end
    endtask

    // Starting on the cycle grant is first seen, ticks until done rises.
    task automatic measure_slot(input int max, output int n, output int low,
                                output int q_last, output bit wrapped,
                                output bit grant_moved, output bit ok);
        logic [N-1:0] g0;
        int prev;
        g0 = grant;
        n = 0;
        low = (cnt_reset === 1'b0) ? 1 : 0;
        wrapped = 1'b0;
        grant_moved = 1'b0;
        ok = 1'b0;
        prev = int'(cnt_q);
        while (n < max && !ok) begin
            prev = int'(cnt_q);
            tick();
            n++;
            if (cnt_reset === 1'b0) low++;
            if (grant !== g0) grant_moved = 1'b1;
            if (done === 1'b1) ok = 1'b1;
            else if (cnt_q == '0) wrapped = 1'b1;
        end
        q_last = prev;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_limit(i, 0);
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || cnt_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_values: grant=%b done=%b busy=%b cnt_reset=%b want 0000/0/0/1",
                     grant, done, busy, cnt_reset);
        end
        req = '0;
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: grant=%b busy=%b want 0000/0", grant, busy);
        end
    endtask

    task automatic test_single();
        int n, low, ql;
        bit wr, gm, ok;
        apply_reset();
        set_limit(0, 5);
        req = 4'b0001;
        tick();
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1 || cnt_reset !== 1'b0) begin
            failures++;
            $display("FAIL single_grant: grant=%b busy=%b cnt_reset=%b want 0001/1/0",
                     grant, busy, cnt_reset);
        end
        measure_slot(50, n, low, ql, wr, gm, ok);
        checks++;
        if (!ok || n != 6) begin
            failures++;
            $display("FAIL single_done_time: got %0d cycles (seen=%0d) want 6", n, ok);
        end
        checks++;
        if (low != 6 || gm) begin
            failures++;
            $display("FAIL single_cnt_reset_low: got %0d cycles grant_moved=%0d want 6/0", low, gm);
        end
        req = '0;
        tick();
        checks++;
        if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || cnt_reset !== 1'b1) begin
            failures++;
            $display("FAIL single_end: grant=%b done=%b busy=%b cnt_reset=%b want 0000/0/0/1",
                     grant, done, busy, cnt_reset);
        end
    endtask

    task automatic test_round_robin();
        int n, low, ql, last_rise, dones;
        bit wr, gm, ok;
        apply_reset();
        for (int i = 0; i < N; i++) set_limit(i, 2);
        req = 4'b1111;
        last_rise = 0;
        dones = 0;
        for (int s = 0; s < 5; s++) begin
            wait_grant(4, n, ok);
            checks++;
            if (!ok || grant !== onehot(s % N)) begin
                failures++;
                $display("FAIL rr_order slot %0d: grant=%b want %b", s, grant, onehot(s % N));
            end
            if (s > 0) begin
                checks++;
                if (cyc - last_rise != 5) begin
                    failures++;
                    $display("FAIL rr_period slot %0d: got %0d want 5", s, cyc - last_rise);
                end
            end
            last_rise = cyc;
            if (s < 4) begin
                measure_slot(20, n, low, ql, wr, gm, ok);
                if (ok) dones++;
                tick();
            end
        end
        checks++;
        if (dones != 4) begin
            failures++;
            $display("FAIL rr_done_count: got %0d want 4", dones);
        end
        req = '0;
        apply_reset();
    endtask

    task automatic test_boundary();
        int n, low, ql;
        bit wr, gm, ok;
        apply_reset();
        set_limit(0, 0);
        req = 4'b0001;
        wait_grant(4, n, ok);
        measure_slot(10, n, low, ql, wr, gm, ok);
        checks++;
        if (!ok || n != 1 || ql != 0) begin
            failures++;
            $display("FAIL limit0: got %0d cycles q=%0d want 1 cycle q=0", n, ql);
        end
        req = '0;
        tick();
        set_limit(0, 255);
        req = 4'b0001;
        wait_grant(4, n, ok);
        checks++;
        if (!ok || grant !== 4'b0010 && grant !== 4'b0001) begin
            failures++;
            $display("FAIL limit255_grant: grant=%b", grant);
        end
        measure_slot(400, n, low, ql, wr, gm, ok);
        checks++;
        if (!ok || n != 256 || ql != 255 || wr) begin
            failures++;
            $display("FAIL limit255: got %0d cycles q=%0d wrap=%0d want 256/255/0", n, ql, wr);
        end
        req = '0;
        tick();
    endtask

    task automatic test_abort();
        int n, low, ql;
        bit wr, gm, ok, saw_done;
        apply_reset();
        set_limit(0, 10);
        set_limit(1, 3);
        req = 4'b0011;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL abort_first_grant: grant=%b want 0001", grant);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        req = 4'b0010;
        tick();
        if (done === 1'b1) saw_done = 1'b1;
        checks++;
        if (grant !== 4'b0000 || cnt_reset !== 1'b1 || busy !== 1'b0 || saw_done) begin
            failures++;
            $display("FAIL abort_release: grant=%b cnt_reset=%b busy=%b done_seen=%0d want 0000/1/0/0",
                     grant, cnt_reset, busy, saw_done);
        end
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL abort_next_grant: grant=%b want 0010", grant);
        end
        measure_slot(20, n, low, ql, wr, gm, ok);
        checks++;
        if (!ok || n != 4) begin
            failures++;
            $display("FAIL abort_next_slot: got %0d cycles want 4", n);
        end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid_slot();
        int n;
        bit ok;
        apply_reset();
        set_limit(2, 20);
        req = 4'b0100;
        wait_grant(4, n, ok);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b0 || cnt_reset !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: grant=%b done=%b busy=%b cnt_reset=%b want 0000/0/0/1",
                     grant, done, busy, cnt_reset);
        end
        tick();
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL reset_wins: grant=%b want 0000", grant);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL reset_rr0: grant=%b want 0001", grant);
        end
        req = '0;
        tick();
    endtask

    task automatic test_limit_change();
        int n, low, ql;
        bit wr, gm, ok;
        apply_reset();
        set_limit(1, 7);
        req = 4'b0010;
        wait_grant(4, n, ok);
        set_limit(1, 2);
        measure_slot(30, n, low, ql, wr, gm, ok);
        checks++;
        if (!ok || n != 8) begin
            failures++;
            $display("FAIL limit_change: got %0d cycles want 8", n);
        end
        req = '0;
        tick();
    endtask

    // Random masks held for several slots; expected winners and slot lengths
    // come from a round-robin pointer and the limit visible at grant time.
    task automatic test_random();
        int n, low, ql, model_rr, w, exp_l;
        bit wr, gm, ok;
        logic [N-1:0] mask;
        apply_reset();
        model_rr = 0;
        for (int r = 0; r < 6; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) set_limit(i, $urandom_range(0, 12));
            req = mask;
            for (int s = 0; s < 4; s++) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && mask[(model_rr + k) % N]) w = (model_rr + k) % N;
                end
                exp_l = get_limit(w);
                wait_grant(3, n, ok);
                checks++;
                if (!ok || n != 1 || grant !== onehot(w)) begin
                    failures++;
                    $display("FAIL rand_grant r%0d s%0d: grant=%b after %0d want %b after 1",
                             r, s, grant, n, onehot(w));
                end
                for (int i = 0; i < N; i++) set_limit(i, $urandom_range(0, 12));
                measure_slot(40, n, low, ql, wr, gm, ok);
                checks++;
                if (!ok || n != exp_l + 1 || ql != exp_l || gm) begin
                    failures++;
                    $display("FAIL rand_slot r%0d s%0d: %0d cycles q=%0d moved=%0d want %0d q=%0d",
                             r, s, n, ql, gm, exp_l + 1, exp_l);
                end
                model_rr = (w + 1) % N;
                tick();
                checks++;
                if (grant !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_idle r%0d s%0d: grant=%b done=%b busy=%b",
                             r, s, grant, done, busy);
                end
            end
            req = '0;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundary();
        test_abort();
        test_reset_mid_slot();
        test_limit_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
